// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divider helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_RECOVER = 3'd4
  } rx_state_t;

  // Clocks per oversample tick; never less than one.
  function automatic int baud_div(input int clk, input int baud, input int os);
    int d;
    d = clk / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic Clock,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/uart_word_receiver.sv
// 8N1 receiver that packs BYTES_PER_WORD bytes (first byte in the low slot) into one word.
// Outputs are plain pulses, no handshake: word_valid marks the single cycle word_data changes.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115_200,
  parameter int OVERSAMPLE     = 16,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                          Clock,
  input  logic                          rst,
  input  logic                          RxD,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_valid,
  output logic                          frame_err,
  output logic                          rx_busy,
  output rx_state_t                     rx_state
);

  localparam int DIV    = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WORD_W = UART_DATA_BITS * BYTES_PER_WORD;

  logic                      tick;
  logic                      rx_s1, rx_s2, rx_s3;
  logic [1:0]                settle;
  logic                      fall;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [IDX_W-1:0]          idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [WORD_W-1:0]         word_buf;
  logic [WORD_W-1:0]         assembled;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .Clock (Clock),
    .rst   (rst),
    .tick  (tick)
  );

  // The settle counter keeps the reset value of the synchroniser from looking like a
  // falling edge when the line is already low at reset release.
  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      settle <= 2'd0;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign fall = (settle == 2'd3) && rx_s3 && !rx_s2;

  always_comb begin
    assembled = word_buf;
    assembled[UART_DATA_BITS*int'(idx) +: UART_DATA_BITS] = shift;
  end

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      idx        <= '0;
      shift      <= '0;
      word_buf   <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (cnt == CNT_W'(OVERSAMPLE/2 - 1)) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
              cnt   <= '0;
              shift <= {rx_s2, shift[UART_DATA_BITS-1:1]};
              if (bit_idx == 3'd7) state <= RX_STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
              cnt <= '0;
              if (rx_s2) begin
                state <= RX_IDLE;
                if (idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                  word_data  <= assembled;
                  word_valid <= 1'b1;
                  word_buf   <= '0;
                  idx        <= '0;
                end else begin
                  word_buf <= assembled;
                  idx      <= idx + IDX_W'(1);
                end
              end else begin
                state     <= RX_RECOVER;
                frame_err <= 1'b1;
                word_buf  <= '0;
                idx       <= '0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RX_RECOVER: begin
          if (rx_s2) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_busy  = (state != RX_IDLE);
  assign rx_state = state;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver at 16 clocks per bit (DIV=1).
module tb_uart_word_receiver;
  import uart_pkg::*;

  localparam int BIT_CLKS = 16;

  logic        Clock;
  logic        rst;
  logic        RxD;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        rx_busy;
  rx_state_t   rx_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          fe_cnt = 0;
  int          wv_cnt = 0;
  logic        both_seen = 1'b0;
  logic        busy_seen = 1'b0;
  logic        beyond_start = 1'b0;

  uart_word_receiver #(
    .CLK_FREQ       (1_600_000),
    .BAUD           (100_000),
    .OVERSAMPLE     (16),
    .BYTES_PER_WORD (4)
  ) dut (
    .Clock      (Clock),
    .rst        (rst),
    .RxD        (RxD),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy),
    .rx_state   (rx_state)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // monitor, sampled away from the active edge
  always @(negedge Clock) begin
    if (!rst) begin
      if (word_valid) begin
        got_q.push_back(word_data);
        wv_cnt++;
      end
      if (frame_err) fe_cnt++;
      if (word_valid && frame_err) both_seen = 1'b1;
      if (rx_busy) busy_seen = 1'b1;
      if (rx_state == RX_DATA || rx_state == RX_STOP || rx_state == RX_RECOVER)
        beyond_start = 1'b1;
    end
  end

  // drivers
  task automatic drive_bit(input logic v);
    RxD = v;
    repeat (BIT_CLKS) @(negedge Clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * BIT_CLKS) @(negedge Clock);
  endtask

  // scoreboard drain: compare captured words against expected, in order
  task automatic check_words(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s word: got none, expected %h", name, e);
      end else begin
        logic [31:0] g;
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL %s word: got %h, expected %h", name, g, e);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RxD = 1'b1;
    repeat (5) @(negedge Clock);
    checks++;
    if (word_data !== 32'h0) begin errors++; $display("FAIL reset word_data: got %h, expected 0", word_data); end
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL reset word_valid: got %b, expected 0", word_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b, expected 0", frame_err); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset rx_busy: got %b, expected 0", rx_busy); end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_single_word();
    int fe0;
    fe0 = fe_cnt;
    got_q.delete();
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL single partial: got %0d words after 3 bytes, expected 0", got_q.size()); end
    send_byte(8'hDE, 1'b1);
    idle_bits(1);
    exp_q.push_back(32'hDEADBEEF);
    check_words("single");
    checks++;
    if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL single frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL single rx_busy: got %b, expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    send_word(32'h04030201);
    send_word(32'h08070605);
    idle_bits(1);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    check_words("b2b");
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = fe_cnt;
    got_q.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    idle_bits(2);
    checks++;
    if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr pulses: got %0d, expected 1", fe_cnt - fe0); end
    send_word(32'h44332211);
    idle_bits(1);
    exp_q.push_back(32'h44332211);
    check_words("ferr");
  endtask

  task automatic test_glitch();
    int fe0, wv0;
    fe0 = fe_cnt;
    wv0 = wv_cnt;
    busy_seen = 1'b0;
    beyond_start = 1'b0;
    RxD = 1'b0;
    repeat (3) @(negedge Clock);
    idle_bits(2);
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch start: rx_busy seen %b, expected 1", busy_seen); end
    checks++;
    if (beyond_start !== 1'b0) begin errors++; $display("FAIL glitch state: went past START %b, expected 0", beyond_start); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch rx_busy: got %b, expected 0", rx_busy); end
    checks++;
    if ((fe_cnt - fe0) + (wv_cnt - wv0) !== 0) begin
      errors++;
      $display("FAIL glitch events: got %0d frame_err and %0d word_valid, expected 0", fe_cnt - fe0, wv_cnt - wv0);
    end
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    got_q.delete();
    RxD = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge Clock);
    idle_bits(2);
    checks++;
    if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL break pulses: got %0d, expected 1", fe_cnt - fe0); end
    send_word(32'hAAAAAAAA);
    idle_bits(1);
    exp_q.push_back(32'hAAAAAAAA);
    check_words("break");
    checks++;
    if (word_data !== 32'hAAAAAAAA) begin errors++; $display("FAIL break word_data: got %h, expected aaaaaaaa", word_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b3;
    b3 = 8'h03;
    got_q.delete();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b3[i]);
    RxD = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge Clock);
    checks++;
    if ({word_data, word_valid, frame_err, rx_busy} !== 35'h0) begin
      errors++;
      $display("FAIL midrst outputs: got data=%h valid=%b ferr=%b busy=%b, expected all 0",
               word_data, word_valid, frame_err, rx_busy);
    end
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge Clock);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst low line: rx_busy %b, expected 0", rx_busy); end
    idle_bits(2);
    send_word(32'h04030201);
    idle_bits(1);
    exp_q.push_back(32'h04030201);
    check_words("midrst");
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL exclusive: word_valid and frame_err together %b, expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
